// File: rtl/rr_arb_pkg.sv
// -----------------------------------------------------------------------------
// rr_arb_pkg
// Shared definitions for the round-robin grant consumer and its helpers:
//   - NUM_CLIENTS / IDX_W     : client count and owner index width
//   - state_e                 : consumer FSM encoding (IDLE / XFER / RELEASE)
//   - GNT_* constants         : one-hot grant patterns as the arbiter drives them
//   - is_onehot4()            : exactly-one-bit-set check for a 4-bit grant
//   - idx_to_onehot()         : 2-bit owner index back to its one-hot request
// -----------------------------------------------------------------------------
package rr_arb_pkg;

    localparam int NUM_CLIENTS = 4;
    localparam int IDX_W       = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XFER    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    localparam logic [NUM_CLIENTS-1:0] GNT_NONE = 4'b0000;
    localparam logic [NUM_CLIENTS-1:0] GNT_C0   = 4'b0001;
    localparam logic [NUM_CLIENTS-1:0] GNT_C1   = 4'b0010;
    localparam logic [NUM_CLIENTS-1:0] GNT_C2   = 4'b0100;
    localparam logic [NUM_CLIENTS-1:0] GNT_C3   = 4'b1000;

    // A vector is one-hot when it is nonzero and clearing its lowest set bit
    // leaves nothing behind.
    function automatic logic is_onehot4(input logic [NUM_CLIENTS-1:0] v);
        return (v != GNT_NONE) && ((v & (v - 4'd1)) == GNT_NONE);
    endfunction

    function automatic logic [NUM_CLIENTS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_CLIENTS-1:0] oh;
        case (idx)
            2'd0:    oh = GNT_C0;
            2'd1:    oh = GNT_C1;
            2'd2:    oh = GNT_C2;
            2'd3:    oh = GNT_C3;
            default: oh = GNT_NONE;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/rr_onehot_enc.sv
// -----------------------------------------------------------------------------
// rr_onehot_enc
// Converts a 4-bit one-hot grant into a 2-bit client index.
// Ports:
//   onehot  in  4  grant vector from the arbiter
//   idx     out 2  index of the set bit (0 when the input is not one-hot)
//   valid   out 1  high when exactly one bit of onehot is set
// -----------------------------------------------------------------------------
module rr_onehot_enc
    import rr_arb_pkg::*;
(
    input  logic [NUM_CLIENTS-1:0] onehot,
    output logic [IDX_W-1:0]       idx,
    output logic                   valid
);

    // Index encoding; anything that is not a clean one-hot pattern maps to 0
    // and is flagged through valid instead.
    always_comb begin
        idx   = 2'd0;
        valid = is_onehot4(onehot);
        case (onehot)
            GNT_C0:  idx = 2'd0;
            GNT_C1:  idx = 2'd1;
            GNT_C2:  idx = 2'd2;
            GNT_C3:  idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

endmodule

// File: rtl/rr_grant_consumer.sv
// -----------------------------------------------------------------------------
// rr_grant_consumer
// Request-side companion to a 4-way round-robin arbiter. Collects per-client
// valid/data bursts, requests the shared channel, consumes the one-hot grant,
// owns the channel for one whole burst and then releases it for one cycle so
// the arbiter can rotate to the next pending client.
//
// Parameters:
//   DATA_W     payload width
//   MAX_BEATS  burst cap; m_last is forced on beat MAX_BEATS
//   TIMEOUT    consecutive owner-idle cycles before a forced release
//              (only with RR_GRANT_TIMEOUT_EN)
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cli_valid/data/last   per-client beat inputs (client i at bit i / slice i)
//   cli_ready             per-client acceptance (only the owner's bit can rise)
//   arb_req, arb_grant    arbiter request vector / one-hot grant
//   m_valid/data/last     shared channel, m_ready from the sink
//   m_owner               index of the current (or last) owner
//   busy                  high in XFER and RELEASE
//   proto_err             1-cycle pulse, the cycle after an illegal grant
//   timeout_err           1-cycle pulse on a stall-timeout release
//                         (port exists only with RR_GRANT_TIMEOUT_EN)
//
// Build option: define RR_GRANT_TIMEOUT_EN to add the stall counter and
// timeout_err. Without it the channel waits indefinitely on a silent owner.
//
// All outputs are forced to 0 while rst is high so the arbiter never sees a
// stale request from an aborted burst.
// -----------------------------------------------------------------------------
module rr_grant_consumer
    import rr_arb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CLIENTS-1:0]        cli_valid,
    input  logic [NUM_CLIENTS*DATA_W-1:0] cli_data,
    input  logic [NUM_CLIENTS-1:0]        cli_last,
    output logic [NUM_CLIENTS-1:0]        cli_ready,
    output logic [NUM_CLIENTS-1:0]        arb_req,
    input  logic [NUM_CLIENTS-1:0]        arb_grant,
    output logic                          m_valid,
    output logic [DATA_W-1:0]             m_data,
    output logic                          m_last,
    input  logic                          m_ready,
    output logic [IDX_W-1:0]              m_owner,
    output logic                          busy,
`ifdef RR_GRANT_TIMEOUT_EN
    output logic                          timeout_err,
`endif
    output logic                          proto_err
);

    localparam int BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic                   proto_err_q, proto_err_d;

`ifdef RR_GRANT_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0]     stall_q, stall_d;
    logic                   timeout_err_q, timeout_err_d;
`endif

    logic [IDX_W-1:0]       gnt_idx_s;
    logic                   gnt_onehot_s;
    logic                   grant_legal_s;
    logic [NUM_CLIENTS-1:0] owner_oh_s;
    logic                   owner_valid_s;
    logic                   owner_last_s;
    logic                   xfer_fire_s;

    rr_onehot_enc u_gnt_enc (
        .onehot (arb_grant),
        .idx    (gnt_idx_s),
        .valid  (gnt_onehot_s)
    );

    // Decode of the grant and of the current owner's beat; the cap forces
    // m_last on the final permitted beat so beat never needs to wrap.
    always_comb begin
        grant_legal_s = gnt_onehot_s && ((arb_grant & cli_valid) != GNT_NONE);
        owner_oh_s    = idx_to_onehot(owner_q);
        owner_valid_s = cli_valid[owner_q];
        owner_last_s  = cli_last[owner_q] || (beat_q == BEAT_W'(MAX_BEATS - 1));
        xfer_fire_s   = (state_q == ST_XFER) && owner_valid_s && m_ready;
    end

    // Next-state logic for the ownership FSM, beat counter and error pulses.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        beat_d      = beat_q;
        proto_err_d = 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
        stall_d       = '0;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                beat_d = '0;
                if (arb_grant == GNT_NONE) begin
                    state_d = ST_IDLE;
                end else if (grant_legal_s) begin
                    owner_d = gnt_idx_s;
                    state_d = ST_XFER;
                end else begin
                    // Multi-hot grant or grant to a silent client: stay put.
                    proto_err_d = 1'b1;
                end
            end
            ST_XFER: begin
                if (xfer_fire_s) begin
                    if (owner_last_s) begin
                        state_d = ST_RELEASE;
                        beat_d  = '0;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                    end
                end else begin
                    // Stall: either the sink is busy or the owner has no beat.
                    beat_d = beat_q;
                end
`ifdef RR_GRANT_TIMEOUT_EN
                // Only a silent owner counts towards the timeout; a busy sink
                // is normal backpressure.
                if (owner_valid_s) begin
                    stall_d = '0;
                end else if (stall_q == STALL_W'(TIMEOUT - 1)) begin
                    stall_d       = '0;
                    state_d       = ST_RELEASE;
                    beat_d        = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
`endif
            end
            ST_RELEASE: begin
                beat_d  = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = '0;
                beat_d  = '0;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            beat_q      <= '0;
            proto_err_q <= 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
            stall_q       <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            beat_q      <= beat_d;
            proto_err_q <= proto_err_d;
`ifdef RR_GRANT_TIMEOUT_EN
            stall_q       <= stall_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    // Output decode from the registered state; everything is held at 0 while
    // rst is asserted.
    always_comb begin
        arb_req   = GNT_NONE;
        cli_ready = GNT_NONE;
        m_valid   = 1'b0;
        m_data    = '0;
        m_last    = 1'b0;
        m_owner   = '0;
        busy      = 1'b0;
        proto_err = 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
        timeout_err = 1'b0;
`endif
        if (rst) begin
            arb_req = GNT_NONE;
        end else begin
            m_owner   = owner_q;
            proto_err = proto_err_q;
`ifdef RR_GRANT_TIMEOUT_EN
            timeout_err = timeout_err_q;
`endif
            case (state_q)
                ST_IDLE: begin
                    arb_req = cli_valid;
                end
                ST_XFER: begin
                    // Requesting only the owner keeps the arbiter's grant stable.
                    arb_req   = owner_oh_s;
                    busy      = 1'b1;
                    m_valid   = owner_valid_s;
                    m_data    = cli_data[owner_q*DATA_W +: DATA_W];
                    m_last    = owner_last_s;
                    cli_ready = owner_oh_s & {NUM_CLIENTS{m_ready}};
                end
                ST_RELEASE: begin
                    // Dropping the old owner lets the arbiter rotate.
                    arb_req = cli_valid & ~owner_oh_s;
                    busy    = 1'b1;
                end
                default: begin
                    arb_req = GNT_NONE;
                end
            endcase
        end
    end

endmodule
